// File: rtl/valid_tag_pipe.sv
// Purpose: multi-channel valid + sideband tag delay pipe with stall, flush and in-flight count.
// Latency: DELAY ce-high cycles (DELAY=0 is a combinational pass-through).
// Backpressure: ce=0 freezes every stage and drops inputs; flush clears valids. Build option VALID_TAG_PIPE_GATE_EN.
module valid_tag_pipe #(
    parameter int WIDTH = 1,
    parameter int TAG_W = 8,
    parameter int DELAY = 4,
    parameter int CNT_W = (DELAY < 1) ? 1 : $clog2(DELAY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             flush,
    input  logic [WIDTH-1:0] i_valid,
    input  logic [TAG_W-1:0] i_tag,
    output logic [WIDTH-1:0] o_valid,
    output logic [TAG_W-1:0] o_tag,
    output logic [CNT_W-1:0] inflight,
    output logic             empty
);

    generate
        if (DELAY == 0) begin : g_bypass
            // No stages: inputs pass straight through, nothing is ever in flight.
            assign o_valid  = i_valid;
            assign o_tag    = i_tag;
            assign inflight = '0;
            assign empty    = 1'b1;
        end else begin : g_pipe
            logic [WIDTH-1:0] vld_q [DELAY];
            logic [TAG_W-1:0] tag_q [DELAY];
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_nxt;
            logic             empty_q;
            logic             cnt_inc;
            logic             cnt_dec;

            // Valid shift register: flush wipes every stage, ce advances, otherwise hold.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    for (int k = 0; k < DELAY; k++) vld_q[k] <= '0;
                end else if (ce) begin
                    vld_q[0] <= i_valid;
                    for (int k = 1; k < DELAY; k++) vld_q[k] <= vld_q[k-1];
                end
            end

            // Tag shift register: untouched by flush; in gated mode a stage only
            // reloads when the valid vector moving into it is non-zero.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < DELAY; k++) tag_q[k] <= '0;
                end else if (!flush && ce) begin
`ifdef VALID_TAG_PIPE_GATE_EN
                    if (|i_valid) tag_q[0] <= i_tag;
                    for (int k = 1; k < DELAY; k++) begin
                        if (|vld_q[k-1]) tag_q[k] <= tag_q[k-1];
                    end
`else
                    tag_q[0] <= i_tag;
                    for (int k = 1; k < DELAY; k++) tag_q[k] <= tag_q[k-1];
`endif
                end
            end

            // Occupancy delta for one advance: an occupied entry enters and/or one leaves.
            always_comb begin
                cnt_inc = |i_valid;
                cnt_dec = |vld_q[DELAY-1];
                cnt_nxt = cnt_q;
                if (cnt_inc && !cnt_dec) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end else if (!cnt_inc && cnt_dec) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end

            // In-flight counter and its registered zero flag move together.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    cnt_q   <= '0;
                    empty_q <= 1'b1;
                end else if (ce) begin
                    cnt_q   <= cnt_nxt;
                    empty_q <= (cnt_nxt == '0);
                end
            end

            assign o_valid  = vld_q[DELAY-1];
            assign o_tag    = tag_q[DELAY-1];
            assign inflight = cnt_q;
            assign empty    = empty_q;
        end
    endgenerate

endmodule

// File: tb/tb_valid_tag_pipe.sv
module tb_valid_tag_pipe;
    localparam int W  = 2;
    localparam int TW = 8;
    localparam int D  = 4;
    localparam int HN = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce;
    logic          flush;
    logic [W-1:0]  i_valid;
    logic [TW-1:0] i_tag;

    logic [W-1:0]  o_valid;
    logic [TW-1:0] o_tag;
    logic [2:0]    inflight;
    logic          empty;

    logic [W-1:0]  o_valid0;
    logic [TW-1:0] o_tag0;
    logic [0:0]    inflight0;
    logic          empty0;

    valid_tag_pipe #(.WIDTH(W), .TAG_W(TW), .DELAY(D)) dut (
        .clk(clk), .reset(reset), .ce(ce), .flush(flush),
        .i_valid(i_valid), .i_tag(i_tag),
        .o_valid(o_valid), .o_tag(o_tag), .inflight(inflight), .empty(empty)
    );

    valid_tag_pipe #(.WIDTH(W), .TAG_W(TW), .DELAY(0)) dut0 (
        .clk(clk), .reset(reset), .ce(ce), .flush(flush),
        .i_valid(i_valid), .i_tag(i_tag),
        .o_valid(o_valid0), .o_tag(o_tag0), .inflight(inflight0), .empty(empty0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of every accepted advance since reset; entries older
    // than the last flush point are dead for valid purposes.
    logic [W-1:0]  hv [HN];
    logic [TW-1:0] ht [HN];
    int            n   = 0;
    int            fat = 0;
    logic [TW-1:0] gtag = '0;

    always @(posedge clk) begin
        if (reset) begin
            n = 0; fat = 0; gtag = '0;
        end else if (flush) begin
            fat = n;
        end else if (ce && n < HN) begin
            hv[n] = i_valid;
            ht[n] = i_tag;
            n++;
            if (n >= D && (n - D) >= fat && hv[n-D] != 0) gtag = ht[n-D];
        end
    end

    function automatic logic [W-1:0] m_valid();
        if (n >= D && (n - D) >= fat) return hv[n-D];
        return '0;
    endfunction

    function automatic logic [TW-1:0] m_tag();
`ifdef VALID_TAG_PIPE_GATE_EN
        return gtag;
`else
        if (n >= D) return ht[n-D];
        return '0;
`endif
    endfunction

    function automatic int m_inflight();
        int c = 0;
        for (int i = n - 1; i >= 0 && i >= n - D; i--)
            if (i >= fat && hv[i] != 0) c++;
        return c;
    endfunction

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("o_valid", o_valid, m_valid());
            check("o_tag", o_tag, m_tag());
            check("inflight", inflight, m_inflight());
            check("empty", empty, m_inflight() == 0);
            check("d0_o_valid", o_valid0, i_valid);
            check("d0_o_tag", o_tag0, i_tag);
            check("d0_inflight", inflight0, 0);
            check("d0_empty", empty0, 1);
        end
    end

    task automatic cyc(input logic [W-1:0] v, input logic [TW-1:0] t,
                       input logic c = 1'b1, input logic f = 1'b0);
        i_valid = v; i_tag = t; ce = c; flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; flush = 1'b0; i_valid = '0; i_tag = '0;
        cyc(2'b11, 8'hFF);
        cyc(2'b11, 8'hFF);
        chk_en = 1'b1;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_tag", o_tag, 0);
        check("rst_inflight", inflight, 0);
        check("rst_empty", empty, 1);
        reset = 1'b0;

        // Single valid through the pipe.
        cyc(2'b01, 8'hA5);
        check("t1_inflight_c1", inflight, 1);
        repeat (3) cyc(2'b00, 8'h00);
        check("t1_o_valid_c4", o_valid, 2'b01);
        check("t1_o_tag_c4", o_tag, 8'hA5);
        check("t1_inflight_c4", inflight, 1);
        cyc(2'b00, 8'h00);
        check("t1_o_valid_c5", o_valid, 0);
        check("t1_inflight_c5", inflight, 0);
        check("t1_empty_c5", empty, 1);

        // Continuous stream, counter saturates at DELAY.
        for (int i = 0; i < 10; i++) begin
            cyc(2'b11, 8'(i));
            if (i == 3) check("t2_first_tag", o_tag, 8'h00);
        end
        check("t2_inflight_sat", inflight, 4);
        check("t2_tag_after10", o_tag, 8'h06);
        repeat (4) cyc(2'b00, 8'h00);
        check("t2_drained", empty, 1);

        // Stall: three ce-low cycles delay the output to cycle 7.
        cyc(2'b01, 8'h11);
        cyc(2'b00, 8'h00);
        repeat (3) cyc(2'b11, 8'h99, 1'b0);
        cyc(2'b00, 8'h00);
        check("t3_not_yet", o_valid, 0);
        cyc(2'b00, 8'h00);
        check("t3_o_valid_c7", o_valid, 2'b01);
        check("t3_o_tag_c7", o_tag, 8'h11);
        cyc(2'b00, 8'h00);
        check("t3_dropped", o_valid, 0);
        check("t3_empty", empty, 1);

        // Flush with three in flight, ce=1 and a valid input.
        cyc(2'b10, 8'h21);
        cyc(2'b10, 8'h22);
        cyc(2'b10, 8'h23);
        check("t4_inflight3", inflight, 3);
        cyc(2'b10, 8'h24, 1'b1, 1'b1);
        check("t4_inflight0", inflight, 0);
        check("t4_empty", empty, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(2'b00, 8'h00);
            check("t4_o_valid_zero", o_valid, 0);
        end

        // Tag behaviour when invalid entries follow a valid one.
        cyc(2'b01, 8'h3C);
        cyc(2'b00, 8'h77);
        cyc(2'b00, 8'h88);
        cyc(2'b00, 8'h00);
        check("t6_tag_valid", o_tag, 8'h3C);
        cyc(2'b00, 8'h00);
`ifdef VALID_TAG_PIPE_GATE_EN
        check("t6_tag_next", o_tag, 8'h3C);
`else
        check("t6_tag_next", o_tag, 8'h77);
`endif
        cyc(2'b00, 8'h00);
`ifdef VALID_TAG_PIPE_GATE_EN
        check("t6_tag_last", o_tag, 8'h3C);
`else
        check("t6_tag_last", o_tag, 8'h88);
`endif

        // Reset mid-stream.
        cyc(2'b01, 8'h5A);
        cyc(2'b10, 8'h5B);
        reset = 1'b1;
        cyc(2'b11, 8'h5C);
        reset = 1'b0;
        check("t7_inflight", inflight, 0);
        check("t7_o_tag", o_tag, 0);
        cyc(2'b01, 8'h61);
        repeat (3) cyc(2'b00, 8'h00);
        check("t7_o_valid", o_valid, 2'b01);
        check("t7_o_tag_out", o_tag, 8'h61);

        // Mixed traffic with stalls and occasional flushes.
        repeat (120) cyc(2'($urandom), 8'($urandom),
                         $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0);
        repeat (6) cyc(2'b00, 8'h00);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
